mem_resp: RTL and testbench
===========================

MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of extra wait cycles between request acceptance and response (0 to 15).
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: the execution unit presents a memory request.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 SHALL have port req_wdata, input, 32 bits: write data.
REQ-009 SHALL have port req_be, input, 4 bits: write byte enables; bit i selects byte i.
REQ-010 SHALL have port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata, output, 32 bits: read data.
REQ-013 SHALL have port rsp_err, output, 1 bit: the request faulted; valid with rsp_valid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request at an edge where state = IDLE and req_valid = 1; there is no other acceptance path.
REQ-016 SHALL, on acceptance at edge k, go to WAIT loading a down-counter with WAIT_CYCLES; if WAIT_CYCLES = 0, it SHALL go directly to RESP.
REQ-017 SHALL decrement the counter each WAIT cycle and enter RESP at the edge where the counter reaches 0; rsp_valid is therefore high exactly in the cycle after edge k+WAIT_CYCLES.
REQ-018 SHALL hold rsp_valid for exactly one cycle, then return to IDLE with no backpressure; req_valid is ignored outside IDLE.
REQ-019 SHALL sample the word index req_addr[31:2], req_we, req_wdata and req_be at acceptance.
REQ-020 SHALL commit a write at the acceptance edge, touching only the bytes enabled in req_be; req_be = 0 is a legal no-op write.
REQ-021 SHALL register read data at the acceptance edge and drive it on rsp_rdata, holding it until the next response; a write response drives rsp_rdata = 0.
REQ-022 SHALL flag out of range when word index >= DEPTH_WORDS: rsp_err = 1, write suppressed, rsp_rdata = 0.
REQ-023 SHALL set rsp_err = 0 on every non-faulting response.
REQ-024 SHALL let a read that immediately follows a write to the same word return the new data.

Reset
REQ-025 SHALL, while rst_n = 0, force state IDLE, counter 0, req_ready = 1 (after release), rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0.
REQ-026 SHALL, on reset asserted mid-operation (WAIT or RESP), drop the pending response; a write already committed at acceptance SHALL remain.
REQ-027 SHALL NOT reset or initialise storage contents.

Configuration
REQ-028 SHALL support macro MEM_RESP_MISALIGN_TRAP_EN.
- Defined: req_addr[1:0] != 0 faults like an out-of-range access (rsp_err = 1, no write, rdata = 0).
- Undefined: req_addr[1:0] is ignored and the word is accessed normally.

Structure
REQ-029 SHALL place in package mem_resp_pkg: the FSM state enum, the WAIT_CYCLES counter width constant, and a request struct {we, addr, wdata, be}.
REQ-030 SHALL isolate storage in sub-module mem_resp_ram: one synchronous write port with byte enables and one registered read port.

Verification
REQ-031 Reset, then write 0xDEADBEEF to 0x10 with be = 0xF and WAIT_CYCLES = 2 -> req_ready low for 3 cycles, rsp_valid one cycle after edge k+2, rsp_err = 0, rsp_rdata = 0.
REQ-032 Read 0x10 -> rsp_rdata = 0xDEADBEEF. Then write 0x000000AA with be = 0x1 and read again -> 0xDEADBEAA.
REQ-033 Read 0x1000 with DEPTH_WORDS = 1024 -> rsp_err = 1, rsp_rdata = 0. A write to 0x1000 leaves word 0 unchanged.
REQ-034 With WAIT_CYCLES = 0, issue back-to-back reads of 0x0 and 0x4 -> responses 2 cycles apart, with req_ready toggling 1,0,1,0.
REQ-035 Assert rst_n = 0 during WAIT of a read -> no rsp_valid, outputs zero, state IDLE after release, and the next request is served normally.
REQ-036 Read 0x12: with MEM_RESP_MISALIGN_TRAP_EN defined -> rsp_err = 1; undefined -> data of word 0x10, rsp_err = 0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types for the mem_resp single-request memory responder.
// Holds the FSM state encoding, the wait-counter width and the request record.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Wide enough for the largest supported WAIT_CYCLES value (15)
   localparam int CNT_W = 4;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

endpackage

// File: rtl/mem_resp_ram.sv
// Word storage for mem_resp: one synchronous byte-enabled write port and one
// registered read port that loads on every accepted request (zero when not a read).
module mem_resp_ram #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           acc,
   input  logic                           wr,
   input  logic                           rd,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [31:0]                    wdata,
   input  logic [3:0]                     be,
   output logic [31:0]                    rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;

   // Storage is deliberately left without reset so contents survive rst_n
   always_ff @(posedge clk) begin
      if (wr) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (acc) begin
         rdata_d = rd ? mem_q[addr] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_resp.sv
// Fixed-latency memory responder: accepts one request in IDLE, waits WAIT_CYCLES,
// then pulses rsp_valid. Optional macro MEM_RESP_MISALIGN_TRAP_EN faults unaligned addresses.
module mem_resp
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW      = $clog2(DEPTH_WORDS);
   localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_err_q, rsp_err_d;

   req_t req;
   logic accept;
   logic fault;
   logic misalign;

   assign req    = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
   assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef MEM_RESP_MISALIGN_TRAP_EN
   assign misalign = |req.addr[1:0];
`else
   logic unused_addr_lsb;
   assign misalign        = 1'b0;
   assign unused_addr_lsb = ^req.addr[1:0];
`endif

   // A faulting request neither writes nor reads; it only reports rsp_err
   assign fault = (req.addr[31:2] >= DEPTH_L) || misalign;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rsp_err_d = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rsp_err_d = fault;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(WAIT_CYCLES);
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      req_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   mem_resp_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .acc   (accept),
      .wr    (accept && req.we && !fault),
      .rd    (!req.we && !fault),
      .addr  (req.addr[AW+1:2]),
      .wdata (req.wdata),
      .be    (req.be),
      .rdata (rsp_rdata)
   );

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed vector table, reset/back-to-back sequences
// and randomized traffic against a word-array reference model.
module tb_mem_resp;

   logic        clk;
   logic        rst_n;
   logic        rv    [2];
   logic        rwe   [2];
   logic [31:0] raddr [2];
   logic [31:0] rwd   [2];
   logic [3:0]  rbe   [2];
   logic        rdy   [2];
   logic        vld   [2];
   logic [31:0] rdat  [2];
   logic        rerr  [2];

   int checks;
   int failures;

   logic [31:0] mdl [int];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   localparam int NV = 13;
   vec_t tbl [NV];

   mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_we(rwe[0]), .req_addr(raddr[0]),
      .req_wdata(rwd[0]), .req_be(rbe[0]), .req_ready(rdy[0]), .rsp_valid(vld[0]),
      .rsp_rdata(rdat[0]), .rsp_err(rerr[0])
   );

   mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_we(rwe[1]), .req_addr(raddr[1]),
      .req_wdata(rwd[1]), .req_be(rbe[1]), .req_ready(rdy[1]), .rsp_valid(vld[1]),
      .rsp_rdata(rdat[1]), .rsp_err(rerr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Reference behaviour of one access computed from the address map and byte enables
   function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, output logic [31:0] rd, output logic err);
      int unsigned idx;
      logic [31:0] w;
      idx = int'(addr >> 2);
      err = (idx >= 1024);
`ifdef MEM_RESP_MISALIGN_TRAP_EN
      if (addr[1:0] != 2'b00) err = 1'b1;
`endif
      rd = '0;
      if (!err) begin
         if (we) begin
            w = mdl[int'(idx)];
            for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
            mdl[int'(idx)] = w;
         end else begin
            rd = mdl[int'(idx)];
         end
      end
   endfunction

   // Called at a negedge with the instance idle; returns at the negedge where it is idle again
   task automatic do_req(input int inst, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output logic err);
      int w;
      logic [7:0] vb, rb;
      w = (inst == 0) ? 2 : 0;
      check("ready_before_req", 32'(rdy[inst]), 32'd1);
      rv[inst] = 1'b1; rwe[inst] = we; raddr[inst] = addr; rwd[inst] = wdata; rbe[inst] = be;
      @(posedge clk);
      vb = '0; rb = '0; rdata = '0; err = 1'b0;
      for (int n = 1; n <= w + 2; n++) begin
         @(negedge clk);
         rv[inst] = 1'b0;
         vb[n-1] = vld[inst];
         rb[n-1] = rdy[inst];
         if (vld[inst]) begin
            rdata = rdat[inst];
            err   = rerr[inst];
         end
      end
      check("rsp_valid_timing", 32'(vb), 32'(8'b1 << w));
      check("req_ready_timing", 32'(rb), 32'(8'b1 << (w + 1)));
   endtask

   initial begin
      logic [31:0] rd, erd, addr;
      logic        er, eer, we;
      logic [3:0]  be;
      int          sel;

      checks = 0; failures = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rv[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rwd[i] = '0; rbe[i] = '0;
      end

      tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0,        1'b0};
      tbl[3]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
      tbl[4]  = '{1'b1, 32'h0,    32'h11223344, 4'hF, 32'h0,        1'b0};
      tbl[5]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        1'b1};
      tbl[6]  = '{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
      tbl[7]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h11223344, 1'b0};
      tbl[8]  = '{1'b1, 32'h10,   32'h55555555, 4'h0, 32'h0,        1'b0};
      tbl[9]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
`ifdef MEM_RESP_MISALIGN_TRAP_EN
      tbl[10] = '{1'b0, 32'h12,   32'h0,        4'h0, 32'h0,        1'b1};
`else
      tbl[10] = '{1'b0, 32'h12,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
`endif
      tbl[11] = '{1'b1, 32'hFFC,  32'h5A5A5A5A, 4'hF, 32'h0,        1'b0};
      tbl[12] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h5A5A5A5A, 1'b0};

      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("reset_rsp_valid", 32'(vld[i]), 32'd0);
         check("reset_rsp_rdata", rdat[i], 32'd0);
         check("reset_rsp_err", 32'(rerr[i]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) check("ready_after_reset", 32'(rdy[i]), 32'd1);

      for (int i = 0; i < NV; i++) begin
         do_req(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er);
         check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
         check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      end

      // Zero-wait instance: back-to-back reads with req_valid held high
      do_req(1, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, rd, er);
      do_req(1, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, rd, er);
      rv[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 32'h0;
      check("b2b_ready0", 32'(rdy[1]), 32'd1);
      @(negedge clk);
      raddr[1] = 32'h4;
      check("b2b_ready1", 32'(rdy[1]), 32'd0);
      check("b2b_valid1", 32'(vld[1]), 32'd1);
      check("b2b_rdata1", rdat[1], 32'hA0A0A0A0);
      @(negedge clk);
      check("b2b_ready2", 32'(rdy[1]), 32'd1);
      check("b2b_valid2", 32'(vld[1]), 32'd0);
      @(negedge clk);
      rv[1] = 1'b0;
      check("b2b_ready3", 32'(rdy[1]), 32'd0);
      check("b2b_valid3", 32'(vld[1]), 32'd1);
      check("b2b_rdata3", rdat[1], 32'hB1B1B1B1);
      @(negedge clk);

      // Reset during WAIT of a write: response dropped, write kept
      rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 32'h20; rwd[0] = 32'hCAFEF00D; rbe[0] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      rv[0] = 1'b0;
      check("wr_wait_ready_low", 32'(rdy[0]), 32'd0);
      rst_n = 1'b0;
      #1;
      check("wr_rst_valid", 32'(vld[0]), 32'd0);
      @(negedge clk);
      check("wr_rst_valid_hold", 32'(vld[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("wr_rst_ready", 32'(rdy[0]), 32'd1);
      check("wr_rst_no_rsp", 32'(vld[0]), 32'd0);

      // Reset during WAIT of a read: outputs cleared, no response
      rv[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 32'h20;
      @(posedge clk);
      @(negedge clk);
      rv[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rd_rst_valid", 32'(vld[0]), 32'd0);
      check("rd_rst_rdata", rdat[0], 32'd0);
      check("rd_rst_err", 32'(rerr[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rd_rst_ready", 32'(rdy[0]), 32'd1);
      check("rd_rst_no_rsp", 32'(vld[0]), 32'd0);
      do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
      check("after_rst_rdata", rd, 32'hCAFEF00D);
      check("after_rst_err", 32'(er), 32'd0);

      // Randomized traffic over a small set of known words plus out-of-range addresses
      for (int i = 0; i < 16; i++) begin
         addr = 32'(i * 4);
         rd = $urandom;
         model(1'b1, addr, rd, 4'hF, erd, eer);
         do_req(0, 1'b1, addr, rd, 4'hF, rd, er);
         check("init_err", 32'(er), 32'(eer));
      end
      model(1'b1, 32'hFFC, 32'h0BADCAFE, 4'hF, erd, eer);
      do_req(0, 1'b1, 32'hFFC, 32'h0BADCAFE, 4'hF, rd, er);
      for (int t = 0; t < 150; t++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      addr = 32'h1000 + ($urandom & 32'hFFF);
         else if (sel == 1) addr = 32'hFFC;
         else if (sel == 2) addr = $urandom | 32'h8000_0000;
         else if (sel == 3) addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         else               addr = 32'($urandom_range(0, 15)) << 2;
         we = 1'($urandom);
         be = 4'($urandom);
         rd = $urandom;
         model(we, addr, rd, be, erd, eer);
         do_req(0, we, addr, rd, be, rd, er);
         check($sformatf("rand%0d_rdata", t), rd, erd);
         check($sformatf("rand%0d_err", t), 32'(er), 32'(eer));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
